// File: rtl/flash_pkg.sv
// Shared definitions for the flash command path: opcodes, FSM states,
// queued-command layout and the SPI flash instruction bytes.
package flash_pkg;

    localparam int ADDR_W = 24;
    localparam int BYTE_W = 8;
    localparam int OP_W   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_READ = 2'd0,
        OP_PP   = 2'd1,
        OP_SE   = 2'd2,
        OP_BE   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Instruction bytes the downstream flash controller shifts out.
    localparam logic [7:0] INSTR_READ = 8'h03;
    localparam logic [7:0] INSTR_PP   = 8'h02;
    localparam logic [7:0] INSTR_SE   = 8'hD8;
    localparam logic [7:0] INSTR_BE   = 8'hC7;
    localparam logic [7:0] INSTR_WREN = 8'h06;
    localparam logic [7:0] INSTR_RDSR = 8'h05;

endpackage

// File: rtl/flash_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; full/empty come straight
// from the registered pointers, and push/pop are gated so it can never
// overflow or underflow.
module flash_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Advance pointers only on accepted push/pop.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/flash_cmd_queue.sv
// Host command queue in front of a flash controller. Commands are buffered
// in a FIFO and issued one at a time as registered level requests; each
// request is held until flash_ack, followed by a mandatory all-low GAP cycle.
module flash_cmd_queue
    import flash_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [BYTE_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [OP_W-1:0]   rsp_op,
    output logic [BYTE_W-1:0] rsp_data,
    output logic              busy,
    output logic              rd_req,
    output logic              pp_req,
    output logic              se_req,
    output logic              be_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] se_addr,
    output logic [BYTE_W-1:0] data_into_flash,
    input  logic              flash_ack,
    input  logic [BYTE_W-1:0] rdata
);

    state_e            state_q, state_d;
    cmd_t              hold_q, hold_d;
    cmd_t              push_cmd, head_cmd;
    logic              fifo_full, fifo_empty, pop;
    logic              rd_req_q, rd_req_d, pp_req_q, pp_req_d;
    logic              se_req_q, se_req_d, be_req_q, be_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] se_addr_q, se_addr_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
    logic [BYTE_W-1:0] rsp_data_q, rsp_data_d;
    logic              issuing;

    assign push_cmd = '{op: op_e'(cmd_op), addr: cmd_addr, wdata: cmd_wdata};

    flash_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_valid),
        .wdata   (push_cmd),
        .pop     (pop),
        .rdata   (head_cmd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign cmd_ready       = !fifo_full;
    assign busy            = !fifo_empty || (state_q != ST_IDLE);
    assign rd_req          = rd_req_q;
    assign pp_req          = pp_req_q;
    assign se_req          = se_req_q;
    assign be_req          = be_req_q;
    assign rd_addr         = rd_addr_q;
    assign wr_addr         = wr_addr_q;
    assign se_addr         = se_addr_q;
    assign data_into_flash = data_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_op          = rsp_op_q;
    assign rsp_data        = rsp_data_q;

    // Next state, pop/hold control, and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = head_cmd;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (flash_ack) state_d = ST_GAP;
            end
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are computed from the next state.
        issuing   = (state_d == ST_ISSUE);
        rd_req_d  = issuing && (hold_d.op == OP_READ);
        pp_req_d  = issuing && (hold_d.op == OP_PP);
        se_req_d  = issuing && (hold_d.op == OP_SE);
        be_req_d  = issuing && (hold_d.op == OP_BE);
        rd_addr_d = rd_req_d ? hold_d.addr  : '0;
        wr_addr_d = pp_req_d ? hold_d.addr  : '0;
        se_addr_d = se_req_d ? hold_d.addr  : '0;
        data_d    = pp_req_d ? hold_d.wdata : '0;

        // Acks are only meaningful while a request is outstanding.
        rsp_valid_d = (state_q == ST_ISSUE) && flash_ack;
        rsp_op_d    = rsp_valid_d ? hold_q.op : '0;
        rsp_data_d  = (rsp_valid_d && (hold_q.op == OP_READ)) ? rdata : '0;
    end

    // State, hold and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            rd_req_q    <= 1'b0;
            pp_req_q    <= 1'b0;
            se_req_q    <= 1'b0;
            be_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            se_addr_q   <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            rd_req_q    <= rd_req_d;
            pp_req_q    <= pp_req_d;
            se_req_q    <= se_req_d;
            be_req_q    <= be_req_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            se_addr_q   <= se_addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_op_q    <= rsp_op_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_flash_cmd_queue.sv
// Directed bench for flash_cmd_queue (DEPTH=4).
module tb_flash_cmd_queue;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        rd_req, pp_req, se_req, be_req;
    logic [23:0] rd_addr, wr_addr, se_addr;
    logic [7:0]  data_into_flash;
    logic        flash_ack;
    logic [7:0]  rdata;
    logic [3:0]  reqs;

    int checks   = 0;
    int failures = 0;

    assign reqs = {rd_req, pp_req, se_req, be_req};

    flash_cmd_queue #(.DEPTH(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_op          (rsp_op),
        .rsp_data        (rsp_data),
        .busy            (busy),
        .rd_req          (rd_req),
        .pp_req          (pp_req),
        .se_req          (se_req),
        .be_req          (be_req),
        .rd_addr         (rd_addr),
        .wr_addr         (wr_addr),
        .se_addr         (se_addr),
        .data_into_flash (data_into_flash),
        .flash_ack       (flash_ack),
        .rdata           (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (reqs == 4'b0000 && k < 50) begin
            step();
            k++;
        end
        chk({tag, "_wait"}, 32'(k < 50), 32'd1);
    endtask

    task automatic ack(input logic [7:0] rd);
        flash_ack = 1'b1;
        rdata     = rd;
        step();
        flash_ack = 1'b0;
        rdata     = 8'h00;
    endtask

    initial begin
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 24'h0;
        cmd_wdata = 8'h0;
        flash_ack = 1'b0;
        rdata     = 8'h0;
        #1 reset_n = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_reqs", reqs, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_op", rsp_op, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_se_addr", se_addr, 0);
        chk("rst_data", data_into_flash, 0);

        // READ, pushed in the first clock after reset release
        reset_n   = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_addr  = 24'h012345;
        chk("rd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("rd_busy", busy, 1);
        chk("rd_nobypass", rd_req, 0);
        step();
        chk("rd_req", reqs, 4'b1000);
        chk("rd_addr", rd_addr, 24'h012345);
        chk("rd_wr_addr0", wr_addr, 0);
        chk("rd_se_addr0", se_addr, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("rd_hold", rd_req, 1);
        end
        chk("rd_no_early_rsp", rsp_valid, 0);
        ack(8'hA5);
        chk("rd_req_drop", reqs, 0);
        chk("rd_addr_drop", rd_addr, 0);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_op", rsp_op, 0);
        chk("rd_rsp_data", rsp_data, 8'hA5);
        step();
        chk("rd_rsp_pulse", rsp_valid, 0);
        chk("rd_idle_busy", busy, 0);

        // Spurious ack while IDLE
        flash_ack = 1'b1;
        rdata     = 8'h5A;
        step();
        flash_ack = 1'b0;
        rdata     = 8'h00;
        chk("sp_rsp", rsp_valid, 0);
        chk("sp_busy", busy, 0);
        chk("sp_reqs", reqs, 0);
        step();
        chk("sp_rsp2", rsp_valid, 0);

        // Ordering: PP, SE, BE back-to-back
        cmd_valid = 1'b1;
        cmd_op = 2'd1; cmd_addr = 24'h000100; cmd_wdata = 8'h3C;
        step();
        cmd_op = 2'd2; cmd_addr = 24'h010000; cmd_wdata = 8'h77;
        step();
        cmd_op = 2'd3; cmd_addr = 24'hFFFFFF; cmd_wdata = 8'h99;
        step();
        cmd_valid = 1'b0;

        wait_req("pp");
        chk("pp_onehot", reqs, 4'b0100);
        chk("pp_wr_addr", wr_addr, 24'h000100);
        chk("pp_data", data_into_flash, 8'h3C);
        chk("pp_rd_addr0", rd_addr, 0);
        chk("pp_se_addr0", se_addr, 0);
        step();
        ack(8'hEE);
        chk("pp_gap", reqs, 0);
        chk("pp_rsp_valid", rsp_valid, 1);
        chk("pp_rsp_op", rsp_op, 1);
        chk("pp_rsp_data", rsp_data, 0);

        wait_req("se");
        chk("se_onehot", reqs, 4'b0010);
        chk("se_addr", se_addr, 24'h010000);
        chk("se_wr_addr0", wr_addr, 0);
        chk("se_data0", data_into_flash, 0);
        ack(8'hEE);
        chk("se_gap", reqs, 0);
        chk("se_rsp_valid", rsp_valid, 1);
        chk("se_rsp_op", rsp_op, 2);
        chk("se_rsp_data", rsp_data, 0);

        wait_req("be");
        chk("be_onehot", reqs, 4'b0001);
        chk("be_rd_addr0", rd_addr, 0);
        chk("be_wr_addr0", wr_addr, 0);
        chk("be_se_addr0", se_addr, 0);
        chk("be_data0", data_into_flash, 0);
        step();
        step();
        chk("be_wait", be_req, 1);
        ack(8'hEE);
        chk("be_gap", reqs, 0);
        chk("be_rsp_valid", rsp_valid, 1);
        chk("be_rsp_op", rsp_op, 3);
        step();
        chk("be_idle_busy", busy, 0);

        // Full: five READs accepted with ack withheld, sixth stalls
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        for (int i = 0; i < 5; i++) begin
            cmd_addr = 24'(i);
            chk("full_ready_pre", cmd_ready, 1);
            step();
        end
        cmd_addr = 24'd5;
        chk("full_ready_low", cmd_ready, 0);
        chk("full_inflight_req", rd_req, 1);
        chk("full_inflight_addr", rd_addr, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_stall", cmd_ready, 0);
        end
        ack(8'h10);
        chk("full_rsp0_valid", rsp_valid, 1);
        chk("full_rsp0_data", rsp_data, 8'h10);
        chk("full_gap_ready", cmd_ready, 0);
        step();
        chk("full_idle_ready", cmd_ready, 0);
        // Pop edge: the pending push is refused in the same cycle
        step();
        chk("sim_ready_after_pop", cmd_ready, 1);
        chk("sim_next_addr", rd_addr, 1);
        step();
        cmd_valid = 1'b0;
        chk("sim_push_taken", cmd_ready, 0);
        for (int j = 1; j <= 5; j++) begin
            wait_req("drain");
            chk("drain_addr", rd_addr, 32'(j));
            ack(8'(8'h10 + j));
            chk("drain_rsp_valid", rsp_valid, 1);
            chk("drain_rsp_data", rsp_data, 32'(8'h10 + j));
        end
        step();
        chk("drain_busy", busy, 0);

        // Reset while a PP is issuing with an SE queued behind it
        cmd_valid = 1'b1;
        cmd_op = 2'd1; cmd_addr = 24'h0000AA; cmd_wdata = 8'h55;
        step();
        cmd_op = 2'd2; cmd_addr = 24'h020000;
        step();
        cmd_valid = 1'b0;
        chk("rp_pp_req", pp_req, 1);
        chk("rp_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rp_async_pp_req", pp_req, 0);
        chk("rp_async_busy", busy, 0);
        chk("rp_async_ready", cmd_ready, 1);
        chk("rp_async_wr_addr", wr_addr, 0);
        chk("rp_async_data", data_into_flash, 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rp_no_rsp", rsp_valid, 0);
            chk("rp_no_req", reqs, 0);
            chk("rp_empty", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
